// File: rtl/bfsk_pkg.sv
// Shared BFSK link constants, the transmit state encoding and the quarter-wave
// sine table used to build the modulator ROM.
package bfsk_pkg;

  localparam int DEF_CLKS_PER_BIT = 100;
  localparam int DEF_PHASE_W      = 16;
  localparam int DEF_LUT_ADDR_W   = 6;
  localparam int DEF_AMP_W        = 8;
  localparam int DEF_FTW0         = 2048;
  localparam int DEF_FTW1         = 4096;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } bfsk_state_t;

  // round(127 * sin(2*pi*k/64)); only the first quarter is stored, the rest
  // follows from mirror symmetry within a half period and sign in the second half.
  function automatic logic signed [7:0] sine_entry(input logic [5:0] k);
    logic [4:0]        j;
    logic [4:0]        q;
    logic signed [7:0] mag;
    j = k[4:0];
    q = (j > 5'd16) ? 5'(6'd32 - {1'b0, j}) : j;
    case (q)
      5'd0:    mag = 8'sd0;
      5'd1:    mag = 8'sd12;
      5'd2:    mag = 8'sd25;
      5'd3:    mag = 8'sd37;
      5'd4:    mag = 8'sd49;
      5'd5:    mag = 8'sd60;
      5'd6:    mag = 8'sd71;
      5'd7:    mag = 8'sd81;
      5'd8:    mag = 8'sd90;
      5'd9:    mag = 8'sd98;
      5'd10:   mag = 8'sd106;
      5'd11:   mag = 8'sd112;
      5'd12:   mag = 8'sd117;
      5'd13:   mag = 8'sd122;
      5'd14:   mag = 8'sd125;
      5'd15:   mag = 8'sd126;
      5'd16:   mag = 8'sd127;
      default: mag = 8'sd0;
    endcase
    return k[5] ? -mag : mag;
  endfunction

endpackage

// File: rtl/bfsk_sine_lut.sv
// Sine ROM with a registered output; forces the sample to zero when not enabled
// so the DAC path sees silence outside a transmission.
module bfsk_sine_lut
  import bfsk_pkg::*;
#(
  parameter int LUT_ADDR_W = DEF_LUT_ADDR_W,
  parameter int AMP_W      = DEF_AMP_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [LUT_ADDR_W-1:0]   addr,
  output logic signed [AMP_W-1:0] sample
);

  if (LUT_ADDR_W != 6 || AMP_W != 8) begin : g_bad_cfg
    $error("bfsk_sine_lut: table is built for LUT_ADDR_W=6 and AMP_W=8");
  end

  logic signed [AMP_W-1:0] rom [2**LUT_ADDR_W];

  for (genvar k = 0; k < 2**LUT_ADDR_W; k++) begin : g_rom
    assign rom[k] = AMP_W'(sine_entry(6'(k)));
  end

  // NOTE: the ROM contents are constants and are never reset; only the output
  // register is, which keeps the table mappable to block ROM or plain LUTs.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for every registered value, so all flops
    // update from the same pre-edge values regardless of statement order.
    if (reset) begin
      sample <= '0;
    end else if (en) begin
      sample <= rom[addr];
    end else begin
      sample <= '0;
    end
  end

endmodule

// File: rtl/bfsk_modulator.sv
// Binary FSK transmitter: serialises data_in one bit per CLKS_PER_BIT clocks and
// emits a continuous-phase sine at FTW0 (bit 0) or FTW1 (bit 1).
module bfsk_modulator
  import bfsk_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int PHASE_W      = DEF_PHASE_W,
  parameter int LUT_ADDR_W   = DEF_LUT_ADDR_W,
  parameter int AMP_W        = DEF_AMP_W,
  parameter int FTW0         = DEF_FTW0,
  parameter int FTW1         = DEF_FTW1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    data_in,
  output logic signed [AMP_W-1:0] sample_out,
  output logic                    sample_valid,
  output logic                    bit_strobe,
  output logic                    busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PHASE_W-1:0] FTW0_W   = PHASE_W'(FTW0);
  localparam logic [PHASE_W-1:0] FTW1_W   = PHASE_W'(FTW1);

  bfsk_state_t        state;
  logic [PHASE_W-1:0] phase;
  logic [CNT_W-1:0]   bit_cnt;
  logic               cur_bit;
  logic               stop_pend;
  logic [PHASE_W-1:0] ftw;
  logic               at_boundary;

  // NOTE: every signal written here gets a value on every path, so no latch.
  always_comb begin
    ftw         = cur_bit ? FTW1_W : FTW0_W;
    at_boundary = (bit_cnt == LAST_CNT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      phase        <= '0;
      bit_cnt      <= '0;
      cur_bit      <= 1'b0;
      stop_pend    <= 1'b0;
      sample_valid <= 1'b0;
      bit_strobe   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      bit_strobe   <= 1'b0;
      sample_valid <= (state == RUN);
      case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            cur_bit    <= data_in;
            bit_cnt    <= '0;
            phase      <= '0;
            stop_pend  <= 1'b0;
            bit_strobe <= 1'b1;
            busy       <= 1'b1;
          end
        end
        RUN: begin
          // Phase never restarts at bit changes, keeping the waveform continuous.
          phase <= phase + ftw;
          if (!at_boundary) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (stop) stop_pend <= 1'b1;
          end else begin
            bit_cnt <= '0;
            if (stop_pend || stop) begin
              state     <= IDLE;
              busy      <= 1'b0;
              stop_pend <= 1'b0;
            end else begin
              cur_bit    <= data_in;
              bit_strobe <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  bfsk_sine_lut #(
    .LUT_ADDR_W(LUT_ADDR_W),
    .AMP_W     (AMP_W)
  ) u_lut (
    .clk   (clk),
    .reset (reset),
    .en    (state == RUN),
    .addr  (phase[PHASE_W-1 -: LUT_ADDR_W]),
    .sample(sample_out)
  );

endmodule

// File: tb/tb_bfsk_modulator.sv
// Directed bench for bfsk_modulator: reset, first samples, alternating bits,
// sign-crossing loopback demod, stop handling and mid-bit reset.
module tb_bfsk_modulator;

  localparam int CPB = 100;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              stop;
  logic              data_in;
  logic signed [7:0] sample_out;
  logic              sample_valid;
  logic              bit_strobe;
  logic              busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bfsk_modulator dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .data_in     (data_in),
    .sample_out  (sample_out),
    .sample_valid(sample_valid),
    .bit_strobe  (bit_strobe),
    .busy        (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Independent reference: round(127*sin(2*pi*k/64)).
  function automatic int ref_lut(input int k);
    real x;
    x = 127.0 * $sin(2.0 * 3.14159265358979 * k / 64.0);
    return int'(x);
  endfunction

  task automatic test_reset();
    int bad;
    bad   = 0;
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    data_in = 1'b0;
    repeat (20) tick();
    n_cmp++;
    if ({sample_out, sample_valid, bit_strobe, busy} !== 11'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h, expected 0",
               {sample_out, sample_valid, bit_strobe, busy});
    end
    reset = 1'b0;
    repeat (200) begin
      tick();
      if (sample_out !== 8'sd0 || sample_valid !== 1'b0 ||
          bit_strobe !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL idle_quiet: %0d active cycles, expected 0", bad);
    end
  endtask

  task automatic test_first_samples();
    int exp_s [6] = '{0, 25, 49, 71, 90, 106};
    do_reset();
    data_in = 1'b0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (bit_strobe !== 1'b1 || busy !== 1'b1 || sample_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL start_flags: strobe=%b busy=%b valid=%b, expected 1 1 0",
               bit_strobe, busy, sample_valid);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if (sample_out !== exp_s[i] || sample_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL first_sample[%0d]: got %0d valid=%b, expected %0d valid=1",
                 i, sample_out, sample_valid, exp_s[i]);
      end
      if (i == 0) begin
        n_cmp++;
        if (bit_strobe !== 1'b0) begin
          n_bad++;
          $display("FAIL strobe_width: got %b after E1, expected 0", bit_strobe);
        end
      end
    end
  endtask

  task automatic test_alternating();
    logic [15:0] m_phase;
    logic        m_cur;
    int          sbad;
    int          cbad;
    do_reset();
    data_in = 1'b0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    m_phase = '0;
    m_cur   = 1'b0;
    data_in = 1'b1;
    for (int b = 0; b < 100; b++) begin
      sbad = 0;
      cbad = 0;
      for (int c = 1; c <= CPB; c++) begin
        tick();
        if (sample_out !== ref_lut(int'(m_phase[15:10])) || sample_valid !== 1'b1) sbad++;
        m_phase = m_phase + (m_cur ? 16'd4096 : 16'd2048);
        if (bit_strobe !== (c == CPB) || busy !== 1'b1) cbad++;
        if (c == CPB) begin
          m_cur   = data_in;
          data_in = ~data_in;
        end
      end
      n_cmp++;
      if (sbad !== 0) begin
        n_bad++;
        $display("FAIL alt_samples bit %0d: %0d wrong samples, expected 0", b, sbad);
      end
      n_cmp++;
      if (cbad !== 0) begin
        n_bad++;
        $display("FAIL alt_strobe bit %0d: %0d wrong strobe/busy cycles, expected 0", b, cbad);
      end
    end
  endtask

  task automatic test_loopback();
    bit tx  [100];
    bit neg [10002];
    int seed_ret;
    int strobes;
    int trans;
    bit rec;
    seed_ret = $urandom(32'hDEADBEEF);
    for (int i = 0; i < 100; i++) tx[i] = 1'($urandom_range(0, 1));
    do_reset();
    data_in = tx[0];
    start   = 1'b1;
    tick();
    start   = 1'b0;
    data_in = tx[1];
    strobes = 0;
    for (int k = 1; k <= 10001; k++) begin
      tick();
      neg[k] = (sample_out < 0);
      if (bit_strobe === 1'b1) strobes++;
      if (k % CPB == 0) data_in = (k / CPB + 1 < 100) ? tx[k / CPB + 1] : 1'b0;
    end
    for (int b = 0; b < 100; b++) begin
      trans = 0;
      for (int k = 100 * b + 3; k <= 100 * b + 101; k++)
        if (neg[k] != neg[k-1]) trans++;
      rec = (trans >= 10);
      n_cmp++;
      if (rec !== tx[b]) begin
        n_bad++;
        $display("FAIL loopback_bit[%0d]: recovered %0d (%0d crossings), sent %0d",
                 b, rec, trans, tx[b]);
      end
    end
    n_cmp++;
    if (strobes !== 100) begin
      n_bad++;
      $display("FAIL loopback_strobes: got %0d, expected 100", strobes);
    end
  endtask

  task automatic test_stop();
    int  bad;
    int  exp_s [3] = '{0, 49, 90};
    do_reset();
    // stop together with start in IDLE must not pre-arm a stop
    data_in = 1'b0;
    start   = 1'b1;
    stop    = 1'b1;
    tick();
    start   = 1'b0;
    stop    = 1'b0;
    data_in = 1'b1;
    bad = 0;
    for (int k = 1; k <= 401; k++) begin
      start = (k == 150);
      stop  = (k == 337);
      tick();
      if (busy !== (k < 400) || bit_strobe !== (k % CPB == 0 && k < 400) ||
          sample_valid !== (k <= 400)) bad++;
      if (k == 400) begin
        n_cmp++;
        if (busy !== 1'b0 || bit_strobe !== 1'b0 || sample_valid !== 1'b1) begin
          n_bad++;
          $display("FAIL stop_boundary: busy=%b strobe=%b valid=%b, expected 0 0 1",
                   busy, bit_strobe, sample_valid);
        end
      end
      if (k == 401) begin
        n_cmp++;
        if (sample_valid !== 1'b0 || sample_out !== 8'sd0) begin
          n_bad++;
          $display("FAIL stop_valid_fall: valid=%b sample=%0d, expected 0 0",
                   sample_valid, sample_out);
        end
      end
    end
    start = 1'b0;
    stop  = 1'b0;
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL stop_sequence: %0d wrong cycles, expected 0", bad);
    end
    bad  = 0;
    stop = 1'b1;
    repeat (10) begin
      tick();
      if (busy !== 1'b0 || sample_valid !== 1'b0 || bit_strobe !== 1'b0) bad++;
    end
    stop = 1'b0;
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL stop_in_idle: %0d active cycles, expected 0", bad);
    end
    // restart without reset: phase must start from zero again, bit 1 tone
    data_in = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (sample_out !== exp_s[i]) begin
        n_bad++;
        $display("FAIL restart_sample[%0d]: got %0d, expected %0d", i, sample_out, exp_s[i]);
      end
    end
    // stop present only in the boundary cycle still ends the bit there
    for (int k = 4; k <= 100; k++) begin
      stop = (k == 100);
      tick();
    end
    stop = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || bit_strobe !== 1'b0) begin
      n_bad++;
      $display("FAIL stop_at_boundary: busy=%b strobe=%b, expected 0 0", busy, bit_strobe);
    end
    tick();
    n_cmp++;
    if (sample_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stop_at_boundary_valid: got %b, expected 0", sample_valid);
    end
  endtask

  task automatic test_reset_mid();
    int exp_s [3] = '{0, 25, 49};
    do_reset();
    data_in = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (249) tick();
    n_cmp++;
    if (busy !== 1'b1 || sample_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_run: busy=%b valid=%b, expected 1 1", busy, sample_valid);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if ({sample_out, sample_valid, bit_strobe, busy} !== 11'b0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: got %h, expected 0",
               {sample_out, sample_valid, bit_strobe, busy});
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || sample_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset_idle: busy=%b valid=%b, expected 0 0", busy, sample_valid);
    end
    data_in = 1'b0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (bit_strobe !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reset_restart: strobe=%b busy=%b, expected 1 1", bit_strobe, busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (sample_out !== exp_s[i]) begin
        n_bad++;
        $display("FAIL mid_reset_sample[%0d]: got %0d, expected %0d", i, sample_out, exp_s[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_samples();
    test_alternating();
    test_loopback();
    test_stop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bfsk_modulator.md
# bfsk_modulator

Binary FSK transmitter, the transmit end of the BFSK link whose demodulator is exercised at 100 MHz with 100-cycle bit periods. It serialises `data_in` one bit per `CLKS_PER_BIT` clocks. It drives a continuous-phase digital sine from a phase accumulator: tone f0 for bit 0, tone f1 for bit 1. The sample stream feeds the DAC path, or loops back directly to the demodulator in link-level benches.

## Interface
- `CLKS_PER_BIT`, 100, clocks per transmitted bit (≥2)
- `PHASE_W`, 16, phase accumulator width
- `LUT_ADDR_W`, 6, sine LUT address bits (taken from phase MSBs)
- `AMP_W`, 8, signed sample width
- `FTW0`, 2048, tuning word for bit 0 (3.125 MHz at 100 MHz clk); must be < 2^(PHASE_W-1)
- `FTW1`, 4096, tuning word for bit 1 (6.25 MHz); must be < 2^(PHASE_W-1)

- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  begin transmission; sampled in IDLE only
- `stop`  in  1  end transmission at the next bit boundary; sampled in RUN only
- `data_in`  in  1  bit to send, sampled at each bit boundary
- `sample_out`  out  AMP_W  signed sine sample
- `sample_valid`  out  1  `sample_out` is a live modulated sample
- `bit_strobe`  out  1  one-cycle pulse: `data_in` was just latched
- `busy`  out  1  high in RUN

## Operation
- States: IDLE, RUN. Reset forces IDLE. Reset also sets `phase`=0, `bit_cnt`=0, `cur_bit`=0, `stop_pend`=0, `sample_out`=0, `sample_valid`=0, `bit_strobe`=0, `busy`=0.
- IDLE with `start`=1: go to RUN. Set `cur_bit`←`data_in`, `bit_cnt`←0, `phase`←0, `bit_strobe`←1, `busy`←1. `stop` is ignored in IDLE.
- Every RUN cycle: `phase`←`phase`+(`cur_bit` ? `FTW1` : `FTW0`), modulo 2^PHASE_W. No phase reset at bit changes, so phase stays continuous.
- RUN, `bit_cnt`<CLKS_PER_BIT-1: `bit_cnt`++. If `stop`=1, set `stop_pend`←1.
- RUN, `bit_cnt`=CLKS_PER_BIT-1 (bit boundary): `bit_cnt`←0.
  - If `stop_pend` or `stop`: go to IDLE, `busy`←0, clear `stop_pend`.
  - Otherwise: `cur_bit`←`data_in`, `bit_strobe`←1.
- `start` in RUN is ignored.
- LUT address = `phase[PHASE_W-1 -: LUT_ADDR_W]`, no dithering.
- LUT entry k = round((2^(AMP_W-1)-1)·sin(2πk/2^LUT_ADDR_W)), two's complement.
- `sample_out` ← LUT[addr] registered. `sample_valid` ← (state==RUN) registered. In IDLE, `sample_out` is driven to 0 on the next edge.
- Reset mid-bit: return to IDLE immediately and discard the partial bit.

## Timing
- Start edge E0 (`start`=1 in IDLE): `busy`=1 and `bit_strobe`=1 after E0.
- E1: `sample_valid`=1 with `sample_out`=LUT[0]=0. Output latency is 1 clock from phase to sample.
- Bit n occupies exactly CLKS_PER_BIT RUN cycles. `bit_strobe` pulses at E0 + n·CLKS_PER_BIT.
- `data_in` must be stable in the cycle before each strobe edge. Upstream updates it on the `bit_strobe` cycle.
- Stop handling:
  - `stop` asserted during a bit: the current bit completes and `busy` falls at that bit's boundary edge.
  - `stop` asserted exactly at the boundary cycle: takes effect at that boundary.
  - `sample_valid` falls one edge after `busy`.
- `bit_strobe` is high for exactly one cycle and never in IDLE.

## Structure
- Package `bfsk_pkg` holds:
  - default `CLKS_PER_BIT`, `FTW0`, `FTW1`, `PHASE_W`, `AMP_W`, `LUT_ADDR_W`
  - state enum {IDLE, RUN}, shared with the demodulator bench for bit timing
- Sub-module `bfsk_sine_lut`: ROM of 2^LUT_ADDR_W signed entries, generated from the formula above, registered output. The top-level block holds the FSM, bit counter and phase accumulator.

## Test plan
- Reset held for 20 cycles, then released with `start` low: all outputs 0 and state stays IDLE for 200 cycles.
- `start` pulse with `data_in`=0 and defaults: `bit_strobe` at E0, first samples 0, 25, 49, 71, 90, 106 (addr step 2), `busy`=1.
- Alternating 0/1 for 100 bits: `bit_strobe` every 100 cycles exactly. Addr step is 2 in 0-bits and 4 in 1-bits. No phase discontinuity at boundaries (`phase`[n+1]-`phase`[n] ∈ {FTW0, FTW1}).
- Loopback into the demodulator with random seed 32'hDEADBEEF, 100 bits: recovered sequence matches with BER = 0.
- `stop` pulsed at cycle 37 of bit 3: `busy` falls at end of bit 3, `sample_valid` one edge later. `start` in RUN and `stop` in IDLE have no effect.
- `reset` asserted at cycle 50 of bit 2: next edge all outputs 0 and IDLE. A new `start` restarts with `phase`=0.
